// File: rtl/data_memory_copier.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_copier
//  Purpose  : Byte-block copy engine. Acts as initiator on a single-port
//             data memory, alternating one READ and one WRITE cycle per byte
//             to copy i_len bytes from i_src to i_dst in ascending order.
//             Pointers wrap modulo 2^ADDR_W.
//  Ports    : i_clk, i_rst (async, active-high)
//             i_start, i_src, i_dst, i_len   - copy request (sampled in IDLE)
//             o_busy, o_done, o_checksum     - status
//             o_mem_addr, o_mem_data, o_mem_we, o_mem_re, i_mem_data
//                                            - memory port (read data is
//                                              registered by the memory)
//  Options  : DATA_MEMORY_COPIER_CHECKSUM_EN - build the running byte-sum
//             accumulator; when undefined o_checksum is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_copier #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_checksum,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W + 1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W:0]   r_cnt;

    // Start is only honoured in IDLE; requests in any other state are dropped.
    logic w_start_acc;
    assign w_start_acc = (r_state == ST_IDLE) && i_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_src_ptr <= i_src;
                            r_dst_ptr <= i_dst;
                            r_cnt     <= i_len;
                            r_state   <= ST_READ;
                        end else begin
                            // Zero-length copy: report completion, touch no memory.
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_READ: begin
                    r_src_ptr <= r_src_ptr + c_ptr_one;
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_dst_ptr <= r_dst_ptr + c_ptr_one;
                    r_cnt     <= r_cnt - c_cnt_one;
                    r_state   <= (r_cnt == c_cnt_one) ? ST_DONE : ST_READ;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and memory-port signals decode directly from the state and
    // pointer registers so reset clears them without waiting for an edge.
    assign o_busy = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign o_done = (r_state == ST_DONE);

    always_comb begin
        o_mem_addr = '0;
        o_mem_data = '0;
        o_mem_we   = 1'b0;
        o_mem_re   = 1'b0;
        case (r_state)
            ST_READ: begin
                o_mem_re   = 1'b1;
                o_mem_addr = r_src_ptr;
            end
            ST_WRITE: begin
                // Read data issued in the previous READ cycle is returned now
                // and forwarded straight back into the memory.
                o_mem_we   = 1'b1;
                o_mem_addr = r_dst_ptr;
                o_mem_data = i_mem_data;
            end
            default: begin
                o_mem_addr = '0;
            end
        endcase
    end

`ifdef DATA_MEMORY_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    // Cleared on every accepted start (including zero-length) and held from
    // DONE until the next accepted start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (w_start_acc) begin
            r_sum <= '0;
        end else if (r_state == ST_WRITE) begin
            r_sum <= r_sum + i_mem_data;
        end
    end

    assign o_checksum = r_sum;
`else
    logic w_unused_start_acc;
    assign w_unused_start_acc = w_start_acc;
    assign o_checksum         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_copier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_copier
//  Purpose  : Self-checking bench for data_memory_copier with a registered
//             1024 x 8 single-port memory model. Table-driven copies plus
//             hand-written sequences for the ignored restart and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_copier;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [9:0]  i_src;
    logic [9:0]  i_dst;
    logic [10:0] i_len;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_checksum;
    logic [9:0]  o_mem_addr;
    logic [7:0]  o_mem_data;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [1024];

    int checks = 0;
    int errors = 0;

    data_memory_copier #(.ADDR_W(10), .DATA_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_src      (i_src),
        .i_dst      (i_dst),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_checksum (o_checksum),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .o_mem_we   (o_mem_we),
        .o_mem_re   (o_mem_re),
        .i_mem_data (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_addr] <= o_mem_data;
        if (o_mem_re) mem_rdata <= mem[o_mem_addr];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Read and write strobes must never overlap.
    always @(negedge clk) begin
        chk("we_re_exclusive", {31'd0, o_mem_we & o_mem_re}, 32'd0);
    end

    function automatic logic [7:0] exp_ck(logic [7:0] s);
`ifdef DATA_MEMORY_COPIER_CHECKSUM_EN
        return s;
`else
        return 8'h00;
`endif
    endfunction

    typedef struct {
        logic [9:0]       src;
        logic [9:0]       dst;
        logic [10:0]      len;
        logic [7:0]       sum;
        logic [3:0][7:0]  bytes;
        logic [3:0][9:0]  raddr;
    } vec_t;

    // Results of the most recent run_copy call.
    int         done_cyc;
    int         done_cnt;
    int         busy_cnt;
    int         we_cnt;
    logic [7:0] sum_at_done;
    logic [9:0] ra_q[$];

    task automatic run_copy(input logic [9:0] src, input logic [9:0] dst,
                            input logic [10:0] len, input bit pulse_again);
        int budget;
        budget      = 2 * int'(len) + 3;
        done_cyc    = -1;
        done_cnt    = 0;
        busy_cnt    = 0;
        we_cnt      = 0;
        sum_at_done = 8'h00;
        ra_q.delete();
        @(posedge clk); #1;
        i_start = 1'b1; i_src = src; i_dst = dst; i_len = len;
        @(posedge clk); #1;                 // edge E0 has passed: cycle 1
        i_start = 1'b0; i_src = '0; i_dst = '0; i_len = '0;
        for (int c = 1; c <= budget; c++) begin
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                sum_at_done = o_checksum;
            end
            if (o_busy)   busy_cnt++;
            if (o_mem_re) ra_q.push_back(o_mem_addr);
            if (o_mem_we) we_cnt++;
            if (pulse_again && c == 3) begin
                i_start = 1'b1; i_src = 10'h3FE; i_dst = 10'h300; i_len = 11'd2;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
    endtask

    task automatic check_copy(string tag, vec_t v);
        int n;
        n = int'(v.len);
        chk({tag, "_done_cycle"}, done_cyc, 2 * n + 1);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, 2 * n);
        chk({tag, "_writes"}, we_cnt, n);
        chk({tag, "_reads"}, ra_q.size(), n);
        chk({tag, "_sum_at_done"}, {24'd0, sum_at_done}, {24'd0, exp_ck(v.sum)});
        chk({tag, "_sum_held"}, {24'd0, o_checksum}, {24'd0, exp_ck(v.sum)});
        for (int k = 0; k < n && k < 4; k++) begin
            if (k < ra_q.size())
                chk($sformatf("%s_raddr%0d", tag, k), {22'd0, ra_q[k]}, {22'd0, v.raddr[k]});
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, mem[v.dst + 10'(k)]}, {24'd0, v.bytes[k]});
        end
    endtask

    vec_t vecs [5];

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_src = '0; i_dst = '0; i_len = '0;
        mem_rdata = 8'h00;
        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
        mem[10'h010] = 8'h11; mem[10'h011] = 8'h22; mem[10'h012] = 8'h33; mem[10'h013] = 8'h44;
        mem[10'h3FE] = 8'h5A; mem[10'h3FF] = 8'hA5; mem[10'h000] = 8'h01; mem[10'h001] = 8'h02;
        mem[10'h030] = 8'h7E; mem[10'h031] = 8'h01; mem[10'h032] = 8'h02;
        mem[10'h040] = 8'h99;

        // bytes/raddr are packed [3:0], so the rightmost element is index 0.
        vecs[0] = '{src:10'h010, dst:10'h200, len:11'd4, sum:8'hAA,
                    bytes:{8'h44, 8'h33, 8'h22, 8'h11},
                    raddr:{10'h013, 10'h012, 10'h011, 10'h010}};
        vecs[1] = '{src:10'h000, dst:10'h080, len:11'd0, sum:8'h00,
                    bytes:'0, raddr:'0};
        vecs[2] = '{src:10'h3FE, dst:10'h100, len:11'd4, sum:8'h02,
                    bytes:{8'h02, 8'h01, 8'hA5, 8'h5A},
                    raddr:{10'h001, 10'h000, 10'h3FF, 10'h3FE}};
        vecs[3] = '{src:10'h030, dst:10'h031, len:11'd3, sum:8'h7A,
                    bytes:{8'h00, 8'h7E, 8'h7E, 8'h7E},
                    raddr:{10'h000, 10'h032, 10'h031, 10'h030}};
        vecs[4] = '{src:10'h040, dst:10'h050, len:11'd1, sum:8'h99,
                    bytes:{8'h00, 8'h00, 8'h00, 8'h99},
                    raddr:{10'h000, 10'h000, 10'h000, 10'h040}};

        #1;
        chk("reset_outputs", {17'd0, o_busy, o_done, o_checksum, o_mem_we, o_mem_re, o_mem_data},
            32'd0);
        chk("reset_addr", {22'd0, o_mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, 1'b0);
            check_copy($sformatf("vec%0d", i), vecs[i]);
        end

        // Second start during a copy is dropped: one done, nothing at 0x300.
        run_copy(10'h010, 10'h280, 11'd4, 1'b1);
        check_copy("restart_ignored", vecs[0]);
        chk("restart_no_second_copy", {24'd0, mem[10'h300]}, 32'd0);

        // Reset in the third WRITE (cycle 6) aborts the copy.
        @(posedge clk); #1;
        i_start = 1'b1; i_src = 10'h010; i_dst = 10'h2C0; i_len = 11'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_in_write", {31'd0, o_mem_we}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("abort_outputs", {17'd0, o_busy, o_done, o_checksum, o_mem_we, o_mem_re, o_mem_data},
            32'd0);
        chk("abort_addr", {22'd0, o_mem_addr}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (o_done) done_cnt++;
        end
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (o_done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_byte1_kept", {24'd0, mem[10'h2C1]}, 32'h22);
        chk("abort_byte2_unwritten", {24'd0, mem[10'h2C2]}, 32'h00);

        run_copy(10'h010, 10'h2E0, 11'd4, 1'b0);
        check_copy("after_reset", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_copier.md
# data_memory_copier

Byte-block copy engine that acts as the initiator on the data-memory port: it issues read and write strobes to copy a block of bytes from one address to another. It sits between the control logic and the 1024 x 8 data memory. The memory has a single port, so a read and a write cannot happen in the same cycle, and each byte takes one read cycle plus one write cycle. Software or the control FSM starts a copy with a single-cycle pulse and waits for a done pulse.

## Interface
Parameters:
- ADDR_W, default 10: memory address width; the address space is 2^ADDR_W bytes.
- DATA_W, default 8: memory data width.

Ports:
- i_clk, in, 1: clock; all state changes on the rising edge.
- i_rst, in, 1: reset; asynchronous, active-high.
- i_start, in, 1: start request; sampled only in IDLE.
- i_src, in, ADDR_W: source base address; captured when i_start is accepted.
- i_dst, in, ADDR_W: destination base address; captured when i_start is accepted.
- i_len, in, ADDR_W+1: byte count, 0..1024; captured when i_start is accepted.
- o_busy, out, 1: high while in READ or WRITE.
- o_done, out, 1: one-cycle completion pulse.
- o_checksum, out, DATA_W: sum of the copied bytes (see Configuration).
- o_mem_addr, out, ADDR_W: memory address.
- o_mem_data, out, DATA_W: memory write data.
- o_mem_we, out, 1: memory write enable.
- o_mem_re, out, 1: memory read enable.
- i_mem_data, in, DATA_W: memory read data; registered by the memory, valid one cycle after o_mem_re.

## Operation
States: IDLE, READ, WRITE, DONE.

- IDLE, i_start=1, i_len!=0:
  - capture src_ptr=i_src, dst_ptr=i_dst, cnt=i_len.
  - go to READ.
- IDLE, i_start=1, i_len=0: go to DONE. No memory access is made.
- IDLE, i_start=0: stay in IDLE.
- READ:
  - outputs: o_mem_re=1, o_mem_we=0, o_mem_addr=src_ptr.
  - next: WRITE; src_ptr increments.
- WRITE:
  - outputs: o_mem_we=1, o_mem_re=0, o_mem_addr=dst_ptr, o_mem_data=i_mem_data (passed through combinationally).
  - next: dst_ptr increments, cnt decrements.
  - if the cnt before the decrement is 1, go to DONE; otherwise go to READ.
- DONE: o_done=1; go to IDLE unconditionally.
- i_start outside IDLE (READ, WRITE, DONE) is ignored. No queuing.
- o_mem_re and o_mem_we are never both high in the same cycle.
- Pointers wrap modulo 2^ADDR_W: after 1023 comes 0.
- Overlapping regions are copied strictly in ascending order. If dst > src and the regions overlap, the result is a forward-propagated pattern; this behaviour is defined and is not an error.
- In IDLE and DONE: o_mem_addr=0, o_mem_data=0, o_mem_we=0, o_mem_re=0.

## Timing
- Reset (asynchronous): state=IDLE; all pointers and counters 0; every output 0.
- Reset asserted mid-copy aborts the copy immediately. Bytes already written stay written. No o_done pulse is produced.
- Start is accepted at edge E0. READ is active in cycle E0+1 and WRITE in cycle E0+2, alternating after that.
- For N>0 bytes:
  - the last WRITE occupies cycle 2N;
  - o_done is high in cycle 2N+1;
  - the block is back in IDLE at cycle 2N+2 and can accept a new start there.
- For N=0: o_done is high in cycle E0+1.
- o_busy is high for exactly 2N cycles; it is low in the DONE cycle.
- Memory outputs are combinational from state and pointer registers; there are no extra pipeline stages.

## Configuration
- Macro: DATA_MEMORY_COPIER_CHECKSUM_EN.
- Defined:
  - an 8-bit accumulator is cleared when i_start is accepted;
  - each WRITE cycle adds i_mem_data modulo 256;
  - o_checksum shows the accumulator value and is stable from the DONE cycle until the next accepted start;
  - reset sets it to 0.
- Undefined: no accumulator is built; o_checksum is tied to 0.
- Copy behaviour and timing are identical in both builds.

## Test plan
- Memory preloaded with addresses 0x10..0x13 = 0x11, 0x22, 0x33, 0x44. Start with src=0x10, dst=0x200, len=4 -> addresses 0x200..0x203 hold the same bytes, o_done fires in cycle 9, o_busy is high for 8 cycles, o_checksum=0xAA when CHECKSUM_EN is defined (0 otherwise).
- len=0 -> o_done fires in cycle 1, o_mem_we and o_mem_re never assert.
- src=0x3FE, dst=0x100, len=4 -> reads are issued at 0x3FE, 0x3FF, 0x000, 0x001 (wrap-around).
- i_start pulsed again during a copy with different src/dst/len -> ignored; only the first copy executes and exactly one o_done pulse appears.
- i_rst asserted during the third WRITE cycle -> all outputs go to 0 asynchronously, no o_done pulse, and a new start after reset release works normally.
- Every cycle of every test -> assert that o_mem_we and o_mem_re are never both 1.
